// File: rtl/cpu_bus_initiator.sv
// ============================================================================
// Module      : cpu_bus_initiator
// Description : Single-outstanding peripheral bus initiator with timeout.
//               Parks the bus at an unmapped address in read mode when idle.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cpu_bus_initiator #(
    parameter int                   address_width  = 16,
    parameter int                   data_width     = 8,
    parameter logic [address_width-1:0] Idle_Address = 16'hFFFF,
    parameter int                   Timeout_Cycles = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [address_width-1:0] req_address_i,
    input  logic [data_width-1:0]    req_data_i,
    output logic                     rsp_valid_o,
    output logic [data_width-1:0]    rsp_data_o,
    output logic                     rsp_error_o,
    output logic [address_width-1:0] bus_address_o,
    output logic [data_width-1:0]    bus_data_o,
    output logic                     bus_rd_wr_o,
    input  logic [data_width-1:0]    bus_data_i,
    input  logic                     bus_take_controlr_i,
    input  logic                     bus_take_controlw_i
);

    localparam int            c_CNT_W   = $clog2(Timeout_Cycles + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(Timeout_Cycles);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                     r_state;
    logic [c_CNT_W-1:0]         r_cnt;
    logic                       r_rsp_valid;
    logic [data_width-1:0]      r_rsp_data;
    logic                       r_rsp_error;
    logic [address_width-1:0]   r_bus_address;
    logic [data_width-1:0]      r_bus_data;
    logic                       r_bus_rd_wr;
    logic                       w_ack;

    // Only the acknowledge matching the direction of the held transaction counts.
    assign w_ack = r_bus_rd_wr ? bus_take_controlw_i : bus_take_controlr_i;

    assign req_ready_o   = (r_state == S_IDLE) && reset_i;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_error_o   = r_rsp_error;
    assign bus_address_o = r_bus_address;
    assign bus_data_o    = r_bus_data;
    assign bus_rd_wr_o   = r_bus_rd_wr;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_error   <= 1'b0;
            r_bus_address <= Idle_Address;
            r_bus_data    <= '0;
            r_bus_rd_wr   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_bus_address <= req_address_i;
                        r_bus_rd_wr   <= req_write_i;
                        r_bus_data    <= req_write_i ? req_data_i : '0;
                        r_cnt         <= '0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_ack || (r_cnt == c_TIMEOUT)) begin
                        // Acknowledge takes priority over a coincident timeout.
                        r_rsp_valid   <= 1'b1;
                        r_rsp_error   <= ~w_ack;
                        r_rsp_data    <= (w_ack && !r_bus_rd_wr) ? bus_data_i : '0;
                        r_bus_address <= Idle_Address;
                        r_bus_data    <= '0;
                        r_bus_rd_wr   <= 1'b0;
                        r_state       <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cpu_bus_initiator.sv
// ============================================================================
// Module      : tb_cpu_bus_initiator
// Description : Directed bench for cpu_bus_initiator with a small IO
//               controller model mapped at 0x9000-0x9003.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cpu_bus_initiator;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [15:0] req_address_i;
    logic [7:0]  req_data_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_error_o;
    logic [15:0] bus_address_o;
    logic [7:0]  bus_data_o;
    logic        bus_rd_wr_o;
    logic [7:0]  bus_data_i;
    logic        bus_take_controlr_i;
    logic        bus_take_controlw_i;

    always #5 clk = ~clk;

    cpu_bus_initiator dut (
        .clk_i               (clk),
        .reset_i             (reset_i),
        .req_valid_i         (req_valid_i),
        .req_ready_o         (req_ready_o),
        .req_write_i         (req_write_i),
        .req_address_i       (req_address_i),
        .req_data_i          (req_data_i),
        .rsp_valid_o         (rsp_valid_o),
        .rsp_data_o          (rsp_data_o),
        .rsp_error_o         (rsp_error_o),
        .bus_address_o       (bus_address_o),
        .bus_data_o          (bus_data_o),
        .bus_rd_wr_o         (bus_rd_wr_o),
        .bus_data_i          (bus_data_i),
        .bus_take_controlr_i (bus_take_controlr_i),
        .bus_take_controlw_i (bus_take_controlw_i)
    );

    // IO controller model: 0 id, 1 ex_data, 2 irq mask, 3 capture (clear on read)
    logic       p_ackr = 1'b0, p_ackw = 1'b0;
    logic [7:0] p_rd = 8'h00, p_ex = 8'h00, p_mask = 8'h00, p_cap = 8'h00;
    logic       trig = 1'b0, trig_d = 1'b0;
    logic       force_r = 1'b0, force_w = 1'b0;
    logic [7:0] force_d = 8'h00;
    logic       p_sel, irq_o;

    assign p_sel = (bus_address_o[15:2] == 14'h2400);
    assign irq_o = |(p_cap & p_mask);
    assign bus_data_i          = p_rd | force_d;
    assign bus_take_controlr_i = p_ackr | force_r;
    assign bus_take_controlw_i = p_ackw | force_w;

    always @(posedge clk) begin
        p_ackr <= p_sel && !bus_rd_wr_o;
        p_ackw <= p_sel && bus_rd_wr_o;
        trig_d <= trig;
        p_rd   <= 8'h00;
        if (p_sel && !bus_rd_wr_o) begin
            case (bus_address_o[1:0])
                2'd0: p_rd <= 8'h3C;
                2'd1: p_rd <= p_ex;
                2'd2: p_rd <= p_mask;
                default: p_rd <= p_cap;
            endcase
        end
        if (p_sel && bus_rd_wr_o && bus_address_o[1:0] == 2'd1) p_ex   <= bus_data_o;
        if (p_sel && bus_rd_wr_o && bus_address_o[1:0] == 2'd2) p_mask <= bus_data_o;
        p_cap <= ((p_sel && !bus_rd_wr_o && bus_address_o[1:0] == 2'd3) ? 8'h00 : p_cap)
                 | {7'd0, trig && !trig_d};
    end

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        ign;     // hold the opposite-direction ack high throughout
        int          late;    // force the matching ack before edge A+late (0 = never)
        logic [7:0]  fdata;
        logic        err;
        logic [7:0]  rdata;
        int          lat;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int   n;
        logic seen;
        @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        req_valid_i   = 1'b1;
        req_write_i   = v.wr;
        req_address_i = v.addr;
        req_data_i    = v.data;
        if (v.ign) begin
            if (v.wr) begin force_r = 1'b1; force_d = 8'hFF; end
            else force_w = 1'b1;
        end
        @(posedge clk); #1;
        req_valid_i   = 1'b0;
        req_write_i   = ~v.wr;
        req_address_i = ~v.addr;
        req_data_i    = ~v.data;
        seen = 1'b0;
        n    = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            if (v.late == k) begin
                if (v.wr) force_w = 1'b1; else force_r = 1'b1;
                force_d = v.fdata;
            end
            @(posedge clk);
            @(negedge clk);
            if (v.late == k) begin force_r = 1'b0; force_w = 1'b0; force_d = 8'h00; end
            if (k == 1) begin
                chk({tag, "_bus_addr"}, {16'd0, bus_address_o}, {16'd0, v.addr});
                chk({tag, "_bus_rdwr"}, {31'd0, bus_rd_wr_o}, {31'd0, v.wr});
                chk({tag, "_bus_data"}, {24'd0, bus_data_o}, {24'd0, v.wr ? v.data : 8'h00});
            end
            if (rsp_valid_o) begin seen = 1'b1; n = k; end
        end
        force_r = 1'b0; force_w = 1'b0; force_d = 8'h00;
        chk({tag, "_latency"}, n, v.lat);
        chk({tag, "_err"}, {31'd0, rsp_error_o}, {31'd0, v.err});
        chk({tag, "_data"}, {24'd0, rsp_data_o}, {24'd0, v.rdata});
        chk({tag, "_park_addr"}, {16'd0, bus_address_o}, 32'hFFFF);
        chk({tag, "_park_rdwr"}, {31'd0, bus_rd_wr_o}, 32'd0);
        @(negedge clk);
        chk({tag, "_strobe_once"}, {31'd0, rsp_valid_o}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, req_ready_o}, 32'd1);
        chk({tag, "_data_hold"}, {24'd0, rsp_data_o}, {24'd0, v.rdata});
    endtask

    vec_t vecs[12];
    vec_t v;
    logic [7:0] b2b_vals [3];
    int   acc_t [3];
    int   nacc, nstrobe, drops;
    logic acc;

    initial begin
        vecs[0]  = '{1'b1, 16'h9001, 8'hA5, 1'b0, 0,  8'h00, 1'b0, 8'h00, 2};
        vecs[1]  = '{1'b0, 16'h9001, 8'h77, 1'b0, 0,  8'h00, 1'b0, 8'hA5, 2};
        vecs[2]  = '{1'b0, 16'h1234, 8'h00, 1'b0, 0,  8'h00, 1'b1, 8'h00, 17};
        vecs[3]  = '{1'b1, 16'h9002, 8'h0F, 1'b0, 0,  8'h00, 1'b0, 8'h00, 2};
        vecs[4]  = '{1'b0, 16'h9002, 8'h00, 1'b0, 0,  8'h00, 1'b0, 8'h0F, 2};
        vecs[5]  = '{1'b0, 16'h9000, 8'h00, 1'b0, 0,  8'h00, 1'b0, 8'h3C, 2};
        vecs[6]  = '{1'b0, 16'h1234, 8'h00, 1'b1, 0,  8'h00, 1'b1, 8'h00, 17};
        vecs[7]  = '{1'b1, 16'h5678, 8'h99, 1'b1, 0,  8'h00, 1'b1, 8'h00, 17};
        vecs[8]  = '{1'b0, 16'h1234, 8'h00, 1'b0, 17, 8'h5C, 1'b0, 8'h5C, 17};
        vecs[9]  = '{1'b0, 16'h4321, 8'h00, 1'b0, 16, 8'hC3, 1'b0, 8'hC3, 16};
        vecs[10] = '{1'b1, 16'h9001, 8'h5A, 1'b0, 0,  8'h00, 1'b0, 8'h00, 2};
        vecs[11] = '{1'b0, 16'h9001, 8'h00, 1'b0, 0,  8'h00, 1'b0, 8'h5A, 2};

        reset_i = 1'b0; req_valid_i = 1'b1; req_write_i = 1'b0;
        req_address_i = 16'h9001; req_data_i = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data_o}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_error_o}, 32'd0);
        chk("rst_bus_addr", {16'd0, bus_address_o}, 32'hFFFF);
        chk("rst_bus_data", {24'd0, bus_data_o}, 32'd0);
        chk("rst_bus_rdwr", {31'd0, bus_rd_wr_o}, 32'd0);
        req_valid_i = 1'b0;
        reset_i = 1'b1;

        for (int i = 0; i < 12; i++) do_txn(vecs[i], $sformatf("vec%0d", i));
        chk("ex_data_after_write", {24'd0, p_ex}, 32'h5A);

        // Back-to-back writes with req_valid held high
        b2b_vals[0] = 8'h11; b2b_vals[1] = 8'h22; b2b_vals[2] = 8'h33;
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b1; req_address_i = 16'h9001;
        req_data_i = b2b_vals[0];
        nacc = 0; nstrobe = 0;
        for (int c = 0; c < 40; c++) begin
            if (rsp_valid_o) nstrobe++;
            acc = req_valid_i && req_ready_o;
            if (acc && nacc < 3) acc_t[nacc] = c;
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc < 3) req_data_i = b2b_vals[nacc];
                else req_valid_i = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b_accepts", nacc, 3);
        chk("b2b_strobes", nstrobe, 3);
        chk("b2b_gap1", acc_t[1] - acc_t[0], 4);
        chk("b2b_gap2", acc_t[2] - acc_t[1], 4);
        chk("b2b_ex_data", {24'd0, p_ex}, 32'h33);

        // Parking must never read the clear-on-read capture register
        v = '{1'b1, 16'h9002, 8'h01, 1'b0, 0, 8'h00, 1'b0, 8'h00, 2};
        do_txn(v, "mask");
        @(negedge clk); trig = 1'b1;
        @(negedge clk);
        chk("irq_set", {31'd0, irq_o}, 32'd1);
        drops = 0;
        repeat (20) begin
            @(negedge clk);
            if (!irq_o) drops++;
        end
        chk("irq_held_idle", drops, 0);
        v = '{1'b0, 16'h9003, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h01, 2};
        do_txn(v, "irq_read");
        chk("irq_cleared", {31'd0, irq_o}, 32'd0);

        // Reset asserted at edge A+1 of a read
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b0; req_address_i = 16'h9001;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
        chk("mid_rst_rsp_data", {24'd0, rsp_data_o}, 32'd0);
        chk("mid_rst_bus_addr", {16'd0, bus_address_o}, 32'hFFFF);
        chk("mid_rst_bus_rdwr", {31'd0, bus_rd_wr_o}, 32'd0);
        nstrobe = 0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid_o) nstrobe++;
        end
        reset_i = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid_o) nstrobe++;
        end
        chk("mid_rst_no_rsp", nstrobe, 0);
        v = '{1'b0, 16'h9001, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h33, 2};
        do_txn(v, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_bus_initiator.md
# cpu_bus_initiator

Bus initiator for the CPU-side peripheral bus: it accepts single read/write requests over a valid/ready interface, drives address/data/rd_wr onto the bus, and waits for the addressed peripheral's take_controlr/take_controlw acknowledge. It returns read data or a timeout error on a one-cycle response strobe. It sits where a host or bridge (UART command port, debug DMA) needs to reach the same peripherals as the CPU, such as the IO controller, timers and UARTs.

## Interface
- address_width, 16, bus address width
- data_width, 8, bus data width
- Idle_Address, 16'hFFFF, address parked on the bus when no transaction is active; must be unmapped by every peripheral
- Timeout_Cycles, 16, wait edges without acknowledge before error; legal range ≥ 2

- clk_i  in  1  single clock, all logic on rising edge
- reset_i  in  1  synchronous, active-low reset: reset_i == 0 at an edge resets the block
- req_valid_i  in  1  request present
- req_ready_o  out  1  block can accept a request
- req_write_i  in  1  1 = write, 0 = read
- req_address_i  in  address_width  target address
- req_data_i  in  data_width  write data
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_data_o  out  data_width  read data
- rsp_error_o  out  1  timeout flag, qualified by rsp_valid_o
- bus_address_o  out  address_width  bus address
- bus_data_o  out  data_width  bus write data
- bus_rd_wr_o  out  1  1 = write, 0 = read
- bus_data_i  in  data_width  peripheral read data (OR-combined bus)
- bus_take_controlr_i  in  1  read acknowledge (OR of peripherals)
- bus_take_controlw_i  in  1  write acknowledge (OR of peripherals)

## Operation
- FSM states: IDLE, WAIT, RESP. All outputs are registered, except that req_ready_o = (state == IDLE) && reset_i.
- IDLE:
  - Bus parked: bus_address_o = Idle_Address, bus_rd_wr_o = 0, bus_data_o = 0.
  - On an edge with req_valid_i && req_ready_o: load the bus from the request, clear the counter, go to WAIT.
  - bus_data_o = req_data_i for writes and 0 for reads.
- WAIT:
  - Bus held constant.
  - Acknowledge is bus_take_controlw_i for writes and bus_take_controlr_i for reads. The other acknowledge line is ignored.
  - On an edge with the acknowledge high: rsp_data_o = bus_data_i for reads, or 0 for writes; rsp_error_o = 0; rsp_valid_o = 1; bus returns to park; go to RESP.
  - Otherwise, if counter == Timeout_Cycles: rsp_error_o = 1, rsp_data_o = 0, rsp_valid_o = 1; bus returns to park; go to RESP.
  - Otherwise the counter increments.
  - If an acknowledge and a timeout occur on the same edge, the acknowledge wins.
- RESP: lasts one cycle. At the next edge rsp_valid_o = 0 and the state goes to IDLE. rsp_data_o and rsp_error_o hold until the next response.
- The bus is always parked at Idle_Address in read mode outside WAIT. This prevents read side effects such as clearing an IRQ register.
- Counter width: $clog2(Timeout_Cycles+1). The counter saturates and never wraps.
- Reset (reset_i == 0 at any edge, including mid-WAIT):
  - State goes to IDLE, counter = 0.
  - rsp_valid_o = 0, rsp_data_o = 0, rsp_error_o = 0.
  - bus_address_o = Idle_Address, bus_data_o = 0, bus_rd_wr_o = 0.
  - req_ready_o = 0 while reset_i is low.
  - The outstanding transaction is dropped and no response is issued.

## Timing
- Accept edge A: the bus carries the transaction from A onward.
- Peripherals register their acknowledge at A+1. The earliest capture is edge A+2, with rsp_valid_o high during cycle A+2 to A+3.
- An acknowledge sampled at edge A+1 reflects the parked bus and is never a valid acknowledge.
- Timeout: the error response is registered at edge A+1+Timeout_Cycles (A+17 at the default).
- req_ready_o reasserts after edge A+3. The next accept is no earlier than A+4, so back-to-back throughput is 1 transaction per 4 cycles.
- The bus is parked for at least edges A+2 and A+3. Peripheral acknowledges are therefore back to 0 before the next WAIT samples them.
- The request fields are sampled only at the accept edge. Changes afterwards have no effect.

## Test plan
- Setup: IO controller with BaseAddress 16'h9000.
- Write 0x9001 data 0xA5, accepted at A -> rsp_valid_o at A+2, rsp_error_o = 0, rsp_data_o = 0x00; the IO controller's ex_data_o = 0xA5 afterwards.
- Read 0x9001 after the write -> rsp_valid_o at A+2 with rsp_data_o = 0xA5, rsp_error_o = 0; bus_address_o = 0xFFFF from A+2.
- Read unmapped 0x1234 -> no acknowledge; rsp_valid_o with rsp_error_o = 1 and rsp_data_o = 0 exactly at edge A+17; single-cycle strobe.
- Hold req_valid_i high with 3 writes queued back-to-back -> accepts at A, A+4, A+8; req_ready_o low in between; exactly 3 strobes.
- Set the IRQ mask, trigger an input edge, then issue 20 idle cycles -> irq_o stays 1 (parking never reads 0x9003). Read 0x9003 -> irq_o clears and the captured bit pattern is returned.
- Assert reset_i = 0 at edge A+1 of a read -> no rsp_valid_o ever; all outputs at reset values; the first request accepted after reset_i = 1 completes normally.
